// File: rtl/avg_accumulator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// avg_accumulator
//
// Block averager that sits in front of a shared 64-bit start/ready divider.
// Sums NUM_SAMPLES unsigned samples, hands the block sum to the divider with a
// one-cycle start pulse, captures quotient/remainder when the divider reports
// ready, optionally rounds half up, and presents the average with a one-cycle
// avg_valid pulse. Accumulation of the next block never stalls. A block that
// completes while the divider path is not idle is dropped and flagged by the
// sticky overrun bit.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   sample_valid  qualifies sample
//   sample        unsigned measurement, W bits
//   div_start     one-cycle start pulse to the divider
//   div_divident  block sum, held from start until the divider is ready again
//   div_divider   constant NUM_SAMPLES
//   div_quotient  divider quotient
//   div_reminder  divider remainder
//   div_ready     divider idle / result valid
//   avg_valid     one-cycle pulse, avg and avg_rem valid
//   avg           block average, held until the next avg_valid
//   avg_rem       unrounded division remainder
//   overrun       sticky, a completed block was dropped
//   busy          FSM is not idle
// -----------------------------------------------------------------------------
module avg_accumulator #(
  parameter int unsigned   N           = 64,
  parameter int unsigned   W           = 32,
  parameter logic [N-1:0]  NUM_SAMPLES = N'(100000),
  parameter bit            ROUND       = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_valid,
  input  logic [W-1:0] sample,
  output logic         div_start,
  output logic [N-1:0] div_divident,
  output logic [N-1:0] div_divider,
  input  logic [N-1:0] div_quotient,
  input  logic [N-1:0] div_reminder,
  input  logic         div_ready,
  output logic         avg_valid,
  output logic [N-1:0] avg,
  output logic [N-1:0] avg_rem,
  output logic         overrun,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_SYNC,   // waiting for a possibly stale division to drain after reset
    S_IDLE,   // ready to launch the next block
    S_START,  // start pulse to the divider
    S_GUARD,  // divider ready still reflects the previous idle state
    S_WAIT,   // waiting for the quotient
    S_DONE    // average presented
  } state_t;

  localparam logic [N-1:0] LAST_IDX = NUM_SAMPLES - N'(1);

  state_t       state, state_next;
  logic [N-1:0] acc;
  logic [N-1:0] cnt;
  logic [N-1:0] sum_next;
  logic         block_done;
  logic         load_div;
  logic         capture;
  logic [N:0]   rem_x2;
  logic         round_up;

  // ---------------------------------------------------------------------------
  // Accumulator: runs independently of the FSM so sampling never stalls.
  // ---------------------------------------------------------------------------
  assign sum_next   = acc + N'(sample);
  assign block_done = sample_valid && (cnt == LAST_IDX);

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking = here would create order-dependent behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_valid) begin
      if (block_done) begin
        // The completing sample belongs to the finished block (in sum_next);
        // the next block starts empty.
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum_next;
        cnt <= cnt + N'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_SYNC;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load_div   = 1'b0;
    capture    = 1'b0;
    unique case (state)
      S_SYNC:  if (div_ready) state_next = S_IDLE;
      S_IDLE: begin
        if (block_done) begin
          load_div   = 1'b1;
          state_next = S_START;
        end
      end
      S_START: state_next = S_GUARD;
      // The divider drops ready only after it has sampled start, so ready is
      // meaningless for one cycle.
      S_GUARD: state_next = S_WAIT;
      S_WAIT: begin
        if (div_ready) begin
          capture    = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_SYNC;
    endcase
  end

  // Round half up: compare 2*rem against the divisor with one extra bit so the
  // doubling can never wrap.
  assign rem_x2   = {div_reminder, 1'b0};
  assign round_up = ROUND && (rem_x2 >= {1'b0, NUM_SAMPLES});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_divident <= '0;
      avg          <= '0;
      avg_rem      <= '0;
      overrun      <= 1'b0;
    end else begin
      if (load_div) begin
        div_divident <= sum_next;
      end
      if (capture) begin
        avg     <= div_quotient + N'(round_up);
        avg_rem <= div_reminder;
      end
      // Any block that completes outside IDLE is discarded, never queued.
      if (block_done && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  assign div_start   = (state == S_START);
  assign avg_valid   = (state == S_DONE);
  assign busy        = (state != S_IDLE);
  assign div_divider = NUM_SAMPLES;

endmodule

// File: tb/tb_avg_accumulator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_avg_accumulator
//
// Four averagers with different parameters share one clock and reset, each
// paired with a behavioural start/ready divider (65 cycles from start sampled
// to ready, so avg_valid lands 67 cycles after the completing sample edge).
// The dividers have no reset and power up in the middle of a stale division.
//   inst 0: NUM_SAMPLES=4,    ROUND=0
//   inst 1: NUM_SAMPLES=4,    ROUND=1
//   inst 2: NUM_SAMPLES=2,    ROUND=0
//   inst 3: NUM_SAMPLES=3000, ROUND=0 (full-scale samples)
// -----------------------------------------------------------------------------
module tb_avg_accumulator;

  localparam int NI          = 4;
  localparam int NS [NI]     = '{4, 4, 2, 3000};
  localparam bit RD [NI]     = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam int DIV_LAT     = 65;
  localparam int EXP_LAT     = 67;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sv   [NI] = '{default: 1'b0};
  logic [31:0] smp  [NI] = '{default: '0};
  logic        ds   [NI];
  logic [63:0] dd   [NI];
  logic [63:0] dv   [NI];
  logic        rdy  [NI];
  logic        av   [NI];
  logic [63:0] avg_val [NI];
  logic [63:0] arem [NI];
  logic        ovr  [NI];
  logic        bsy  [NI];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    int unsigned dcnt = 30;   // stale division in flight at power-up
    logic [63:0] q_r  = '0;
    logic [63:0] r_r  = '0;

    avg_accumulator #(
      .N           (64),
      .W           (32),
      .NUM_SAMPLES (64'(NS[g])),
      .ROUND       (RD[g])
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sv[g]),
      .sample       (smp[g]),
      .div_start    (ds[g]),
      .div_divident (dd[g]),
      .div_divider  (dv[g]),
      .div_quotient (q_r),
      .div_reminder (r_r),
      .div_ready    (rdy[g]),
      .avg_valid    (av[g]),
      .avg          (avg_val[g]),
      .avg_rem      (arem[g]),
      .overrun      (ovr[g]),
      .busy         (bsy[g])
    );

    assign rdy[g] = (dcnt == 0);

    always @(posedge clk) begin
      if (dcnt != 0) begin
        dcnt <= dcnt - 1;
      end else if (ds[g]) begin
        dcnt <= DIV_LAT;
        q_r  <= dd[g] / dv[g];
        r_r  <= dd[g] % dv[g];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i, input logic [31:0] v);
    @(negedge clk);
    sv[i]  = 1'b1;
    smp[i] = v;
  endtask

  task automatic gap(input int i, input int n);
    repeat (n) begin
      @(negedge clk);
      sv[i] = 1'b0;
    end
  endtask

  // Call right after put() of the completing sample.
  task automatic finish_block(input int i, input string tag, input logic [63:0] exp_dd,
                              input logic [63:0] exp_avg, input logic [63:0] exp_rem);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    @(posedge clk); #1;
    check({tag, " start"}, ds[i], 1'b1);
    check({tag, " divident"}, dd[i], exp_dd);
    sv[i] = 1'b0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(posedge clk); #1;
      if (av[i]) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check({tag, " latency"}, lat, EXP_LAT);
    check({tag, " avg"}, avg_val[i], exp_avg);
    check({tag, " avg_rem"}, arem[i], exp_rem);
    @(posedge clk); #1;
    check({tag, " pulse width"}, av[i], 1'b0);
  endtask

  initial begin
    int pulses;
    int bad;
    bit seen;
    logic [63:0] first_avg, first_rem;

    // ---------------- reset and SYNC ----------------
    repeat (3) @(negedge clk);
    check("rst avg", avg_val[0], 64'd0);
    check("rst avg_rem", arem[0], 64'd0);
    check("rst avg_valid", av[0], 1'b0);
    check("rst div_start", ds[0], 1'b0);
    check("rst divident", dd[0], 64'd0);
    check("rst overrun", ovr[0], 1'b0);
    check("rst busy in sync", bsy[0], 1'b1);
    check("divider const 4", dv[0], 64'd4);
    check("divider const 3000", dv[3], 64'd3000);
    rst_n = 1'b1;

    // A block completing while still in SYNC is dropped.
    for (int k = 0; k < 4; k++) put(1, 32'd1);
    gap(1, 1);
    check("sync drop overrun", ovr[1], 1'b1);
    check("sync busy", bsy[1], 1'b1);
    check("other overrun", ovr[0], 1'b0);

    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (!bsy[0] && !bsy[1] && !bsy[2] && !bsy[3]) seen = 1'b1;
    end
    check("leave sync", seen, 1'b1);

    // ---------------- truncating average ----------------
    put(0, 32'd10); put(0, 32'd20); put(0, 32'd30); put(0, 32'd41);
    finish_block(0, "trunc101", 64'd101, 64'd25, 64'd1);

    // ---------------- rounding ----------------
    put(1, 32'd10); put(1, 32'd20); put(1, 32'd30); put(1, 32'd41);
    finish_block(1, "round101", 64'd101, 64'd25, 64'd1);
    put(1, 32'd10); put(1, 32'd20); put(1, 32'd30); put(1, 32'd42);
    finish_block(1, "round102", 64'd102, 64'd26, 64'd2);

    // ---------------- repeated blocks with gaps ----------------
    for (int b = 0; b < 2; b++) begin
      gap(0, 35);
      put(0, 32'd7); put(0, 32'd7); put(0, 32'd7); put(0, 32'd7);
      finish_block(0, "sevens", 64'd28, 64'd7, 64'd0);
    end
    gap(0, 35);
    put(0, 32'd7); gap(0, 3); put(0, 32'd7); gap(0, 1); put(0, 32'd7); gap(0, 5); put(0, 32'd7);
    finish_block(0, "sevens gapped", 64'd28, 64'd7, 64'd0);
    check("sevens overrun", ovr[0], 1'b0);

    // ---------------- overrun with NUM_SAMPLES=2 ----------------
    pulses    = 0;
    first_avg = '0;
    first_rem = '0;
    put(2, 32'd5); put(2, 32'd8);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (av[2]) begin
        pulses++;
        first_avg = avg_val[2];
        first_rem = arem[2];
      end
      sv[2]  = 1'b1;
      smp[2] = 32'd3;
    end
    @(negedge clk);
    sv[2] = 1'b0;
    check("stream pulses", pulses, 1);
    check("stream first avg", first_avg, 64'd6);
    check("stream first rem", first_rem, 64'd1);
    check("stream overrun", ovr[2], 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (av[2]) seen = 1'b1;
    end
    check("stream second pulse", seen, 1'b1);
    check("stream second divident", dd[2], 64'd6);
    check("stream second avg", avg_val[2], 64'd3);
    check("stream second rem", arem[2], 64'd0);

    // ---------------- full-scale samples ----------------
    for (int k = 0; k < 2999; k++) put(3, 32'hFFFF_FFFF);
    put(3, 32'hFFFF_FFFF);
    finish_block(3, "fullscale", 64'h0000_0BB7_FFFF_F448, 64'h0000_0000_FFFF_FFFF, 64'd0);

    // ---------------- reset mid-division ----------------
    put(0, 32'd1); put(0, 32'd2); put(0, 32'd3); put(0, 32'd4);
    @(posedge clk); #1;
    check("midrst start", ds[0], 1'b1);
    sv[0] = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst busy", bsy[0], 1'b1);
    check("midrst avg cleared", avg_val[0], 64'd0);
    check("midrst overrun cleared", ovr[2], 1'b0);
    bad  = 0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk); #1;
      if (av[0]) bad++;
      if (rdy[0]) seen = 1'b1;
      else if (!bsy[0]) bad++;
    end
    check("midrst ready returns", seen, 1'b1);
    check("midrst sync hold", bad, 0);
    check("midrst busy at ready", bsy[0], 1'b1);
    @(posedge clk); #1;
    check("midrst idle", bsy[0], 1'b0);
    check("midrst no pulse", av[0], 1'b0);
    put(0, 32'd100); put(0, 32'd200); put(0, 32'd300); put(0, 32'd403);
    finish_block(0, "after rst", 64'd1003, 64'd250, 64'd3);
    check("after rst overrun", ovr[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/avg_accumulator.md
Name: avg_accumulator

Overview:
- Front end of the measurement-averaging path and the initiator side of the 64-bit start/ready divider.
- Sums a block of NUM_SAMPLES unsigned samples, then launches one division of the sum by NUM_SAMPLES.
- Captures the quotient, optionally rounds it, and presents the block average with a one-cycle valid pulse.
- Accumulation of the next block continues while the division runs.

Parameters:
- N, 64, divider operand width; accumulator and result width.
- W, 32, input sample width; unsigned.
- NUM_SAMPLES, 100000, samples per block; also the divisor. Legal range 1..2^N-1.
- ROUND, 0, 0 = truncate; 1 = round half up (quotient+1 when 2*remainder >= NUM_SAMPLES).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- sample_valid  in  1  sample qualifier.
- sample  in  W  unsigned measurement.
- div_start  out  1  to divider start; one-cycle pulse.
- div_divident  out  N  block sum; held stable from the start pulse until div_ready returns.
- div_divider  out  N  constant NUM_SAMPLES.
- div_quotient  in  N  divider quotient.
- div_reminder  in  N  divider remainder.
- div_ready  in  1  divider idle / result valid.
- avg_valid  out  1  one-cycle pulse; avg and avg_rem are valid.
- avg  out  N  block average; held until the next avg_valid.
- avg_rem  out  N  remainder of the division (unrounded).
- overrun  out  1  sticky; a completed block was dropped because the divider was busy.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n=0 at an edge):
  - accumulator, sample counter, div_divident, avg and avg_rem <= 0.
  - div_start, avg_valid, overrun <= 0; FSM <= SYNC.
- Accumulation (independent of the FSM):
  - On sample_valid, acc <= acc + zero-extended sample and cnt <= cnt + 1.
  - When sample_valid is high and cnt == NUM_SAMPLES-1, the block completes: sum_next = acc + sample.
  - On completion, acc <= 0 and cnt <= 0 in the same edge. The completing sample belongs to the finished block; the next sample starts the new block.
  - No saturation. Integration must guarantee NUM_SAMPLES*(2^W-1) < 2^N. The defaults use 49 bits.
- FSM states:
  - SYNC: entered after reset. The divider has no reset and may still be finishing a stale division. Wait for div_ready=1, then go to IDLE. Blocks completing in SYNC set overrun and are dropped.
  - IDLE: on block completion, div_divident <= sum_next and go to START.
  - START: div_start=1 for exactly this cycle; go to GUARD.
  - GUARD: one cycle. Ignore div_ready here, because the divider's ready deasserts only after it samples start. Go to WAIT.
  - WAIT: when div_ready=1, capture the result and go to DONE.
    - avg <= div_quotient + (ROUND && 2*div_reminder >= NUM_SAMPLES).
    - Compute 2*div_reminder with N+1 bits; no overflow.
    - avg_rem <= div_reminder.
  - DONE: avg_valid=1 for this cycle; go to IDLE. A block completing in the same cycle as DONE is dropped (overrun), not queued.
- Latency: completing sample edge → START 1 cycle → GUARD → 64 divider cycles → DONE. avg_valid asserts 67 cycles after the completing-sample edge for N=64.
- Overrun:
  - A block that completes in any state other than IDLE is discarded and overrun <= 1.
  - Accumulation is never stalled.
  - overrun clears only on reset.
- div_divider is the constant NUM_SAMPLES at all times.
- Reset mid-division: the FSM returns to SYNC and no avg_valid is issued for the interrupted block. The first start is not issued until div_ready=1 has been seen.
- sample_valid gaps: any number of idle cycles between samples are allowed; cnt counts only valid cycles.

Test Plan:
1. NUM_SAMPLES=4, ROUND=0, samples 10, 20, 30, 41 back-to-back → div_divident=101, avg_valid once with avg=25 and avg_rem=1, 67 cycles after the 4th sample.
2. Same stimulus with ROUND=1 → avg=25 (2*1<4). With samples 10, 20, 30, 42: sum 102, rem 2 → avg=26.
3. NUM_SAMPLES=4, continuous samples of value 7 for 3 blocks, with 100-cycle gaps between blocks → three avg_valid pulses, each avg=7, avg_rem=0, overrun=0.
4. NUM_SAMPLES=2, continuous samples (block completes every 2 cycles) → first block averaged; following blocks completing during START/GUARD/WAIT/DONE are dropped; overrun=1; accumulator values stay correct for the next block accepted in IDLE.
5. Assert rst_n=0 for 1 cycle, 20 cycles into a division; the bench divider model keeps running → no avg_valid for that block, busy stays high in SYNC until div_ready=1, and the next block produces a correct average.
6. W=32, NUM_SAMPLES=100000, all samples 0xFFFFFFFF → sum 0x1869FFFFE7960, avg=0xFFFFFFFF, avg_rem=0.
